logs_orbit_capture: RTL and testbench
=====================================

// Module: logs_orbit_capture
// PURPOSE
//  Downstream consumer and r-sweep driver for the logistic-map iterator, forming one bifurcation-diagram column per r value.
//  Per column: restart the map, discard SETTLE transient x values, then OR the next SAMPLES x values into a ROWS-bit occupancy bitmap.
//  The finished column goes to the display writer over a valid/ready handshake; r then steps to the next column.
// PARAMETERS
//  FRAC     8    fraction bits of x (0.FRAC) and r (2.FRAC); must match the iterator
//  ROW_BITS 5    log2 of bitmap rows; 1 <= ROW_BITS <= FRAC; ROWS = 2**ROW_BITS
//  COLS     64   columns per frame (>= 2)
//  R_START  640  r of column 0, 2.FRAC encoding (640 = 2.5)
//  R_STEP   6    r increment per column; R_START + (COLS-1)*R_STEP must be < 2**(FRAC+2)
//  SETTLE   32   transient samples discarded per column (>= 1)
//  SAMPLES  64   samples captured per column (>= 1)
// PORTS
//  clk         in   1              clock
//  rst_n       in   1              asynchronous reset, active low
//  x           in   FRAC           iterator output x
//  next_ready  in   1              one-cycle pulse: x holds a new value
//  r           out  FRAC+2         r driven to the iterator
//  map_reset   out  1              active-high synchronous restart of the iterator
//  col_bits    out  2**ROW_BITS    bitmap; bit k set = some sample had row k
//  col_idx     out  clog2(COLS)    column index of col_bits
//  col_valid   out  1              col_bits/col_idx valid
//  col_ready   in   1              display writer accepts the column
//  frame_done  out  1              one-cycle pulse on handshake of column COLS-1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=RESTART, r=R_START, col_idx=0, map_reset=1, col_valid=0, col_bits=0, frame_done=0,
//   sample counter=0, internal bitmap=0.
//  All outputs are registered. Four states:
//  RESTART: lasts exactly 1 cycle; map_reset=1; bitmap and counter cleared; next_ready ignored; -> SETTLE.
//  SETTLE: map_reset=0; each next_ready pulse increments the counter.
//   On the SETTLE-th pulse: counter=0, state -> CAPTURE. The x values seen in this state are never recorded.
//  CAPTURE: on each pulse, bitmap |= 1 << x[FRAC-1 -: ROW_BITS] (the top ROW_BITS bits of x; row 0 = smallest x).
//   On the SAMPLES-th pulse, on the same edge: col_bits <= bitmap including this sample, col_valid <= 1, state -> PRESENT.
//  PRESENT: col_valid, col_bits and col_idx are held stable; next_ready is ignored, so the map free-runs and its samples are lost.
//   On the edge where col_valid & col_ready:
//    col_valid <= 0; state -> RESTART.
//    If col_idx == COLS-1: col_idx <= 0, r <= R_START, frame_done <= 1 for that one cycle.
//    Otherwise: col_idx += 1 and r += R_STEP.
//   The new r is therefore stable before and during map_reset.
//  col_ready while col_valid=0 has no effect. col_ready may be held high permanently; the handshake then completes
//   1 cycle after col_valid rises. col_bits keeps its last value after the handshake until the next column is loaded.
//  r holds its value for the whole column. There is no arithmetic wrap of r; the PARAMETERS constraint excludes it.
//  Reset mid-operation discards the partial column; the sweep restarts at column 0, and no frame_done is emitted.
//  Iterator latency does not affect correctness. Only next_ready pulses are counted; pulse spacing (>= 1 cycle) is arbitrary.
// TESTING
//  Stub iterator (pulse every 4 cycles), x=0xA0 constant, col_ready=1: expect map_reset 1 cycle after reset release;
//   col_valid after exactly 96 pulses; col_bits = 1<<20; col_idx=0; r=640.
//  Settle filter: x=0xFF for the first 32 pulses, then x=0x08 for 64 pulses -> col_bits = 1<<1 only (bit 31 clear).
//  Backpressure: col_ready=0 for 20 cycles after col_valid, pulses continue -> col_valid, col_bits and r stable;
//   no pulses counted; after handshake r=646, col_idx=1, map_reset pulses once.
//  Two-value orbit: alternate x=0x20 and 0xE0 -> col_bits = (1<<4)|(1<<28).
//  Frame wrap: run 64 columns -> frame_done exactly once, on handshake of col_idx=63;
//   the next column has r=640 and col_idx=0.
//  Async reset asserted mid-CAPTURE (with no clock edge) -> outputs immediately at reset values;
//   after release the full 96-pulse sequence repeats for column 0.
//  Integration: with the real iterator (FRAC=8), r=640 (2.5) must produce a single-row column near x=0.6 (row 19).

Source files
------------

// File: rtl/logs_orbit_capture.sv
// Bifurcation-diagram column builder: sweeps r, restarts the logistic-map iterator per column,
// skips the transient, ORs the captured orbit into a row bitmap and hands it off over valid/ready.
module logs_orbit_capture #(
  parameter int unsigned FRAC     = 8,
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned COLS     = 64,
  parameter int unsigned R_START  = 640,
  parameter int unsigned R_STEP   = 6,
  parameter int unsigned SETTLE   = 32,
  parameter int unsigned SAMPLES  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FRAC-1:0]           x,
  input  logic                      next_ready,
  output logic [FRAC+1:0]           r,
  output logic                      map_reset,
  output logic [2**ROW_BITS-1:0]    col_bits,
  output logic [$clog2(COLS)-1:0]   col_idx,
  output logic                      col_valid,
  input  logic                      col_ready,
  output logic                      frame_done
);

  localparam int unsigned ROWS    = 2**ROW_BITS;
  localparam int unsigned R_W     = FRAC + 2;
  localparam int unsigned IDX_W   = $clog2(COLS);
  localparam int unsigned CNT_MAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RESTART,
    ST_SETTLE,
    ST_CAPTURE,
    ST_PRESENT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ROWS-1:0]   bitmap;
  logic [ROWS-1:0]   sample_bit;

  // Row 0 is the smallest x: the row is the top ROW_BITS bits of the fraction.
  always_comb begin
    sample_bit = ROWS'(1) << x[FRAC-1 -: ROW_BITS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESTART;
      r          <= R_W'(R_START);
      col_idx    <= '0;
      map_reset  <= 1'b1;
      col_valid  <= 1'b0;
      col_bits   <= '0;
      frame_done <= 1'b0;
      cnt        <= '0;
      bitmap     <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_RESTART: begin
          map_reset <= 1'b0;
          bitmap    <= '0;
          cnt       <= '0;
          state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (next_ready) begin
            if (cnt == CNT_W'(SETTLE - 1)) begin
              cnt   <= '0;
              state <= ST_CAPTURE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (next_ready) begin
            bitmap <= bitmap | sample_bit;
            if (cnt == CNT_W'(SAMPLES - 1)) begin
              cnt       <= '0;
              col_bits  <= bitmap | sample_bit;
              col_valid <= 1'b1;
              state     <= ST_PRESENT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_PRESENT: begin
          // r/col_idx advance on the handshake so the new r is stable through map_reset.
          if (col_valid && col_ready) begin
            col_valid <= 1'b0;
            map_reset <= 1'b1;
            state     <= ST_RESTART;
            if (col_idx == IDX_W'(COLS - 1)) begin
              col_idx    <= '0;
              r          <= R_W'(R_START);
              frame_done <= 1'b1;
            end else begin
              col_idx <= col_idx + 1'b1;
              r       <= r + R_W'(R_STEP);
            end
          end
        end
        default: state <= ST_RESTART;
      endcase
    end
  end

endmodule

// File: tb/tb_logs_orbit_capture.sv
// Randomized bench for logs_orbit_capture: stub iterator, pulse-count based reference model
// compared every cycle, plus literal expectations for the documented scenarios.
module tb_logs_orbit_capture;

  localparam int unsigned FRAC     = 8;
  localparam int unsigned ROW_BITS = 5;
  localparam int unsigned COLS     = 64;
  localparam int unsigned R_START  = 640;
  localparam int unsigned R_STEP   = 6;
  localparam int unsigned SETTLE   = 32;
  localparam int unsigned SAMPLES  = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [FRAC-1:0]      x;
  logic                 next_ready;
  logic [FRAC+1:0]      r;
  logic                 map_reset;
  logic [31:0]          col_bits;
  logic [5:0]           col_idx;
  logic                 col_valid;
  logic                 col_ready;
  logic                 frame_done;

  logs_orbit_capture #(
    .FRAC(FRAC), .ROW_BITS(ROW_BITS), .COLS(COLS), .R_START(R_START),
    .R_STEP(R_STEP), .SETTLE(SETTLE), .SAMPLES(SAMPLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .next_ready(next_ready), .r(r),
    .map_reset(map_reset), .col_bits(col_bits), .col_idx(col_idx),
    .col_valid(col_valid), .col_ready(col_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub iterator: pulses every `gap` cycles, silent while map_reset is high.
  int  gap = 4, cyc = 0, stub_n = 0, x_mode = 0;
  bit  rand_gap = 0, rand_rdy = 0;

  always @(posedge clk) begin
    #1;
    next_ready = 1'b0;
    if (rand_rdy) col_ready = 1'($urandom_range(0, 1));
    if (map_reset) begin
      stub_n = 0;
      cyc    = 0;
    end else begin
      cyc++;
      if (cyc >= gap) begin
        cyc = 0;
        next_ready = 1'b1;
        case (x_mode)
          0: x = 8'hA0;
          1: x = (stub_n < 32) ? 8'hFF : 8'h08;
          2: x = stub_n[0] ? 8'hE0 : 8'h20;
          default: x = 8'($urandom_range(0, 255));
        endcase
        stub_n++;
        if (rand_gap) gap = $urandom_range(1, 4);
      end
    end
  end

  // Reference model: a column is finished once SETTLE+SAMPLES pulses have been seen since restart.
  bit          m_restart;
  int          m_pulses;
  logic [31:0] m_rows, m_bits;
  bit          m_valid, m_fd;
  int          m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_restart = 1; m_pulses = 0; m_rows = '0; m_bits = '0;
      m_valid = 0; m_fd = 0; m_idx = 0;
    end else begin
      m_fd = 0;
      if (m_restart) begin
        m_restart = 0; m_pulses = 0; m_rows = '0;
      end else if (m_valid) begin
        if (col_ready) begin
          m_valid = 0;
          m_restart = 1;
          if (m_idx == COLS - 1) begin
            m_idx = 0;
            m_fd = 1;
          end else begin
            m_idx++;
          end
        end
      end else if (next_ready) begin
        if (m_pulses >= SETTLE) m_rows[x >> (FRAC - ROW_BITS)] = 1'b1;
        m_pulses++;
        if (m_pulses == SETTLE + SAMPLES) begin
          m_bits  = m_rows;
          m_valid = 1;
        end
      end
    end
  end

  int fd_seen = 0;

  always @(negedge clk) begin
    chk("map_reset", 64'(map_reset), 64'(m_restart));
    chk("col_valid", 64'(col_valid), 64'(m_valid));
    chk("col_bits", 64'(col_bits), 64'(m_bits));
    chk("col_idx", 64'(col_idx), 64'(m_idx));
    chk("r", 64'(r), 64'(R_START + m_idx * R_STEP));
    chk("frame_done", 64'(frame_done), 64'(m_fd));
    if (frame_done) fd_seen++;
  end

  task automatic wait_valid();
    int n = 0;
    while (col_valid && n < 5000) begin @(negedge clk); n++; end
    while (!col_valid && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      fails++;
      $display("FAIL wait_valid timeout actual=%0d required=<5000 cycles", n);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_map_reset"}, 64'(map_reset), 64'd1);
    chk({tag, "_col_valid"}, 64'(col_valid), 64'd0);
    chk({tag, "_col_bits"}, 64'(col_bits), 64'd0);
    chk({tag, "_col_idx"}, 64'(col_idx), 64'd0);
    chk({tag, "_r"}, 64'(r), 64'd640);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    logic [31:0] hold_bits;
    logic [9:0]  hold_r;
    int n;
    rst_n = 1'b0; col_ready = 1'b0; next_ready = 1'b0; x = '0;
    repeat (3) @(posedge clk);
    #2 chk_reset_vals("por");

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_map_reset", 64'(map_reset), 64'd1);
    @(negedge clk);
    chk("map_reset_drop", 64'(map_reset), 64'd0);

    // Column 0: constant x=0xA0, then 20 cycles of backpressure.
    wait_valid();
    chk("c0_pulses", 64'(stub_n), 64'd96);
    chk("c0_bits", 64'(col_bits), 64'h0010_0000);
    chk("c0_idx", 64'(col_idx), 64'd0);
    chk("c0_r", 64'(r), 64'd640);
    hold_bits = col_bits;
    hold_r = r;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(col_valid), 64'd1);
      chk("bp_bits", 64'(col_bits), 64'(hold_bits));
      chk("bp_r", 64'(r), 64'(hold_r));
    end
    x_mode = 1;
    col_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid", 64'(col_valid), 64'd0);
    chk("hs_map_reset", 64'(map_reset), 64'd1);
    chk("hs_r", 64'(r), 64'd646);
    chk("hs_idx", 64'(col_idx), 64'd1);
    chk("hs_keep_bits", 64'(col_bits), 64'h0010_0000);
    @(negedge clk);
    chk("hs_map_reset_once", 64'(map_reset), 64'd0);

    // Column 1: settle filter.
    wait_valid();
    chk("settle_bits", 64'(col_bits), 64'h0000_0002);
    x_mode = 2;
    @(negedge clk);
    chk("ready_high_1cyc", 64'(col_valid), 64'd0);

    // Column 2: two-value orbit.
    wait_valid();
    chk("orbit2_bits", 64'(col_bits), 64'h1000_0010);
    chk("orbit2_r", 64'(r), 64'd652);

    // Random x, pulse spacing and ready until the frame wraps.
    x_mode = 3; rand_gap = 1; rand_rdy = 1;
    n = 0;
    while (fd_seen == 0 && n < 60000) begin @(negedge clk); n++; end
    if (n >= 60000) begin
      fails++;
      $display("FAIL frame_wrap timeout actual=%0d required=<60000 cycles", n);
    end
    rand_rdy = 0; rand_gap = 0; gap = 4; x_mode = 0; col_ready = 1'b1;
    wait_valid();
    chk("wrap_idx", 64'(col_idx), 64'd0);
    chk("wrap_r", 64'(r), 64'd640);
    chk("wrap_bits", 64'(col_bits), 64'h0010_0000);
    chk("wrap_fd_once", 64'(fd_seen), 64'd1);

    // Async reset in the middle of CAPTURE, between clock edges.
    n = 0;
    while (col_valid && n < 100) begin @(negedge clk); n++; end
    while (stub_n < 40 && n < 2000) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid();
    chk("rst_pulses", 64'(stub_n), 64'd96);
    chk("rst_bits", 64'(col_bits), 64'h0010_0000);
    chk("rst_idx", 64'(col_idx), 64'd0);
    chk("rst_fd", 64'(fd_seen), 64'd1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
